// File: rtl/pll_lock_supervisor_pkg.sv
// Purpose : shared types and constants for the PLL lock supervisor slice.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package pll_lock_supervisor_pkg;

    // Supervisor sequencing states.
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int unsigned RELOCK_CNT_W      = 8;
    // Consecutive low synced-lock cycles in RUN before loss is declared
    // when the glitch filter is built in.
    localparam int unsigned GLITCH_FILTER_LEN = 4;

    // Saturating increment for the relock event counter.
    function automatic logic [RELOCK_CNT_W-1:0] sat_inc(input logic [RELOCK_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Purpose : bundles the PLL-facing and system-facing supervisor signals.
// Latency : n/a (wiring only).
// Backpr. : none; all signals are levels or single-cycle pulses.
// Signals : pll_locked_i (async PLL LOCK), force_relock_i (relock request level),
//           pll_rst_o, sys_reset_o, ready_o, lock_lost_o, relock_count_o.
// slave modport = supervisor side, master modport = environment side.
interface pll_lock_supervisor_if;

    logic                                              pll_locked_i;
    logic                                              force_relock_i;
    logic                                              pll_rst_o;
    logic                                              sys_reset_o;
    logic                                              ready_o;
    logic                                              lock_lost_o;
    logic [pll_lock_supervisor_pkg::RELOCK_CNT_W-1:0]  relock_count_o;

    modport slave (
        input  pll_locked_i,
        input  force_relock_i,
        output pll_rst_o,
        output sys_reset_o,
        output ready_o,
        output lock_lost_o,
        output relock_count_o
    );

    modport master (
        output pll_locked_i,
        output force_relock_i,
        input  pll_rst_o,
        input  sys_reset_o,
        input  ready_o,
        input  lock_lost_o,
        input  relock_count_o
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Purpose : 1-bit two-flop synchroniser for asynchronous level inputs.
// Latency : output follows an input change after 2 clk edges.
// Backpr. : none.
// Ports   : clk, reset (async active-high, clears both flops), i_d (async in), o_q (synced out).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Purpose : sequences PLL reset, qualifies lock, retries on timeout, gates system reset.
// Latency : outputs registered from the next state, so they line up with the state register.
// Backpr. : none; force_relock_i is a level sampled every cycle outside PLL_RST.
// Ports   : clk (free-running ref clock), reset (async active-high), bus (slave modport:
//           pll_locked_i, force_relock_i in; pll_rst_o, sys_reset_o, ready_o,
//           lock_lost_o, relock_count_o out).
// Build   : define PLL_LOCK_GLITCH_FILTER_EN to require GLITCH_FILTER_LEN consecutive
//           low synced-lock cycles in RUN before declaring loss.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W               = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    pll_lock_supervisor_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic                    w_locked_s;
    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_loss;
    logic                    w_lost;
    logic                    w_inc;
    logic                    r_pll_rst;
    logic                    r_sys_reset;
    logic                    r_ready;
    logic                    r_lock_lost;
    logic [RELOCK_CNT_W-1:0] r_relock_cnt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.pll_locked_i),
        .o_q   (w_locked_s)
    );

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    // Run length of low synced-lock samples seen while in RUN.
    logic [1:0] r_low_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_low_cnt <= 2'd0;
        end else if (r_state == RUN && !w_locked_s) begin
            r_low_cnt <= r_low_cnt + 2'd1;
        end else begin
            r_low_cnt <= 2'd0;
        end
    end

    // Loss on the final low sample of the run; earlier lows are tolerated.
    assign w_loss = !w_locked_s && (r_low_cnt == 2'(GLITCH_FILTER_LEN - 1));
`else
    assign w_loss = !w_locked_s;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_lost      = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            PLL_RST: begin
                // force_relock_i deliberately not looked at: the pulse always completes.
                if (r_cnt == C_RST_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (bus.force_relock_i) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                end else if (w_locked_s) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TO_LAST) begin
                    w_inc       = 1'b1;
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                end
            end
            STABLE: begin
                if (bus.force_relock_i) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = '0;
                end else if (!w_locked_s) begin
                    // A dropout restarts both qualification and the timeout window.
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                // A requested relock masks a coincident loss: no pulse, no count.
                if (bus.force_relock_i) begin
                    w_state_nxt = PLL_RST;
                end else if (w_loss) begin
                    w_lost      = 1'b1;
                    w_inc       = 1'b1;
                    w_state_nxt = PLL_RST;
                end
            end
            default: begin
                w_state_nxt = PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= PLL_RST;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_sys_reset  <= 1'b1;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_relock_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pll_rst   <= (w_state_nxt == PLL_RST);
            r_sys_reset <= (w_state_nxt != RUN);
            r_ready     <= (w_state_nxt == RUN);
            r_lock_lost <= w_lost;
            if (w_inc) begin
                r_relock_cnt <= sat_inc(r_relock_cnt);
            end
        end
    end

    assign bus.pll_rst_o      = r_pll_rst;
    assign bus.sys_reset_o    = r_sys_reset;
    assign bus.ready_o        = r_ready;
    assign bus.lock_lost_o    = r_lock_lost;
    assign bus.relock_count_o = r_relock_cnt;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Control-side counterpart to the ECP5 EHXPLLL wrapper. It drives the PLL RST input and consumes the PLL LOCK output. It sequences PLL reset pulses, qualifies lock stability, retries on lock timeout, and holds the system reset until the PLL clocks are trustworthy. It runs on the free-running board reference clock (100 MHz), not on any PLL output.

Parameters:
RST_PULSE_CYCLES, 16, clk cycles pll_rst_o is held high per PLL reset pulse (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before releasing sys_reset_o (>=1)
LOCK_TIMEOUT_CYCLES, 100000, cycles to wait for lock after a PLL reset before retrying (>=1)
CNT_W, 17, width of the shared cycle counter; must hold max(all three cycle params)

Ports:
clk  input  1  reference clock, 100 MHz
reset  input  1  asynchronous, active-high reset
pll_locked_i  input  1  PLL LOCK, asynchronous to clk
force_relock_i  input  1  level; request a PLL reset sequence
pll_rst_o  output  1  to PLL RST
sys_reset_o  output  1  active-high reset for downstream PLL clock domains (consumers re-synchronise)
ready_o  output  1  high while in RUN
lock_lost_o  output  1  one-cycle pulse on lock loss detected in RUN
relock_count_o  output  8  saturating count of lock losses plus lock timeouts

Behaviour:
- Reset values (async): pll_rst_o=1, sys_reset_o=1, ready_o=0, lock_lost_o=0, relock_count_o=0, state=PLL_RST, counter=0, synchroniser flops=0.
- pll_locked_i passes through a 2-FF synchroniser. locked_s is valid 2 cycles after an input change. All decisions use locked_s.
- States, encoded in package enum:
  - PLL_RST: pll_rst_o=1. Counter counts up. When counter==RST_PULSE_CYCLES-1, clear counter and go to WAIT_LOCK. pll_rst_o is therefore high for exactly RST_PULSE_CYCLES cycles after reset deassertion.
  - WAIT_LOCK: pll_rst_o=0. If locked_s=1, clear counter and go to STABLE. Otherwise count. When counter==LOCK_TIMEOUT_CYCLES-1, increment relock_count_o and go to PLL_RST.
  - STABLE: counts while locked_s=1. If locked_s=0, clear counter and go to WAIT_LOCK (no count increment; timeout restarts). When counter==LOCK_STABLE_CYCLES-1, go to RUN.
  - RUN: sys_reset_o=0, ready_o=1. On loss detect: lock_lost_o=1 for one cycle, increment relock_count_o, go to PLL_RST.
- sys_reset_o=1 and ready_o=0 in every state except RUN. All outputs are registered, with one-cycle state-to-output latency.
- force_relock_i=1 in WAIT_LOCK, STABLE or RUN goes to PLL_RST next cycle and clears the counter. No count increment and no lock_lost_o. It is ignored in PLL_RST. If held high, the block loops through PLL_RST/WAIT_LOCK each cycle it is sampled outside PLL_RST.
- Priority in RUN: force_relock_i over loss detect. Simultaneous force and loss gives no pulse and no increment.
- relock_count_o saturates at 255. It is cleared only by reset.
- Mid-operation reset returns immediately to the reset values and restarts the sequence.

Optional Feature:
Macro: PLL_LOCK_GLITCH_FILTER_EN
- Defined: in RUN, loss is declared only after locked_s is low for 4 consecutive cycles. A 2-bit low-run counter is cleared whenever locked_s=1. Loss-detect latency is 2 sync + 4 cycles.
- Undefined: a single locked_s=0 cycle in RUN declares loss.
- STABLE and WAIT_LOCK behaviour is identical either way.

Decomposition:
- Package pll_lock_supervisor_pkg: state enum (PLL_RST, WAIT_LOCK, STABLE, RUN), RELOCK_CNT_W=8 constant, GLITCH_FILTER_LEN=4 constant.
- Sub-module sync_2ff (1-bit, async active-high reset to 0): reusable for other CDC inputs.

Test Plan (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32):
- Reset release, lock rises 10 cycles later and stays -> pll_rst_o high exactly 4 cycles. sys_reset_o falls 2+8+1 cycles after lock rises. ready_o=1, relock_count_o=0.
- Lock never asserts -> pll_rst_o re-pulses every 4+32 cycles. relock_count_o increments each timeout and saturates at 255 after 255 timeouts.
- In STABLE, lock drops for 1 cycle at stable count 5 -> returns to WAIT_LOCK. Full 8 stable cycles are required again. Count unchanged.
- In RUN, lock drops for 1 cycle -> undefined macro: lock_lost_o single pulse, relock_count_o=1, pll_rst_o pulse, sys_reset_o=1. Defined macro: no reaction. A 4-cycle drop does trigger.
- In RUN, force_relock_i pulsed 1 cycle coincident with a lock drop -> PLL_RST next cycle, lock_lost_o stays 0, count unchanged.
- Reset asserted mid-STABLE -> all outputs at reset values in the same cycle, asynchronously. Sequence restarts cleanly on release.
